// File: rtl/object_spawn_pkg.sv
// Shared definitions for the object spawn sequencer: ROM entry layout, FSM encoding, direction codes.
package object_spawn_pkg;

    localparam int ENTRY_W = 67;
    localparam int WAIT_W  = 8;

    // Field LSB positions inside a ROM word (MSB-first layout)
    localparam int LAST_LSB  = 0;
    localparam int H_LSB     = 1;
    localparam int W_LSB     = 11;
    localparam int TRIG_LSB  = 21;
    localparam int DTIME_LSB = 23;
    localparam int SPEED_LSB = 31;
    localparam int Y_LSB     = 36;
    localparam int X_LSB     = 46;
    localparam int DIR_LSB   = 56;
    localparam int WAIT_LSB  = 59;

    localparam logic [2:0] DIR_UP         = 3'd0;
    localparam logic [2:0] DIR_UP_RIGHT   = 3'd1;
    localparam logic [2:0] DIR_RIGHT      = 3'd2;
    localparam logic [2:0] DIR_DOWN_RIGHT = 3'd3;
    localparam logic [2:0] DIR_DOWN       = 3'd4;
    localparam logic [2:0] DIR_DOWN_LEFT  = 3'd5;
    localparam logic [2:0] DIR_LEFT       = 3'd6;
    localparam logic [2:0] DIR_UP_LEFT    = 3'd7;

    typedef struct packed {
        logic [2:0] dir;
        logic [9:0] x;
        logic [9:0] y;
        logic [4:0] speed;
        logic [7:0] destroy_time;
        logic [1:0] trigger;
        logic [9:0] w;
        logic [9:0] h;
        logic       last;
    } attr_t;

    typedef struct packed {
        logic [WAIT_W-1:0] wait_cs;
        attr_t             attr;
    } entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_DELAY,
        S_FIND_SLOT,
        S_LOAD,
        S_RELEASE
    } state_t;

endpackage

// File: rtl/object_spawn_sequencer_arbiter.sv
// Combinational lowest-index pick among slots that are free and not yet claimed.
module object_slot_arbiter #(
    parameter int NUM_SLOTS = 8,
    parameter int IDX_W     = 3
) (
    input  logic [NUM_SLOTS-1:0] object_free,
    input  logic [NUM_SLOTS-1:0] claimed,
    output logic                 found,
    output logic [IDX_W-1:0]     index
);

    logic [NUM_SLOTS-1:0] candidates;

    always_comb begin
        candidates = object_free & ~claimed;
        found      = 1'b0;
        index      = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (candidates[i]) begin
                found = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/object_spawn_sequencer.sv
// Walks an attack-pattern ROM, waits each entry's delay, claims the lowest free slot and pulses
// its active-low load strobe for the LOAD cycle while the shared attribute bus is held stable.
module object_spawn_sequencer #(
    parameter int NUM_SLOTS = 8,
    parameter int ADDR_W    = 8,
    parameter int ENTRY_W   = object_spawn_pkg::ENTRY_W
) (
    input  logic                 clk_centi_second,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    pattern_base,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic [ENTRY_W-1:0]   rom_data,
    input  logic [NUM_SLOTS-1:0] object_free,
    output logic [NUM_SLOTS-1:0] sync_object_position,
    output logic [2:0]           movement_direction,
    output logic [9:0]           object_pos_x,
    output logic [9:0]           object_pos_y,
    output logic [4:0]           object_speed,
    output logic [7:0]           object_destroy_time,
    output logic [1:0]           object_destroy_trigger,
    output logic [9:0]           object_w,
    output logic [9:0]           object_h,
    output logic                 busy,
    output logic                 pattern_done,
    output logic [7:0]           stall_count
);

    import object_spawn_pkg::*;

    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    state_t               state, state_n;
    entry_t               rom_entry;
    attr_t                entry_q;
    logic [WAIT_W-1:0]    delay_cnt;
    logic [NUM_SLOTS-1:0] claimed, claimed_n;
    logic [IDX_W-1:0]     slot_q, slot_idx;
    logic                 slot_found;

    assign rom_entry = entry_t'(rom_data);

    object_slot_arbiter #(
        .NUM_SLOTS (NUM_SLOTS),
        .IDX_W     (IDX_W)
    ) u_arbiter (
        .object_free (object_free),
        .claimed     (claimed),
        .found       (slot_found),
        .index       (slot_idx)
    );

    always_ff @(posedge clk_centi_second) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:      if (start) state_n = S_FETCH;
            S_FETCH:     state_n = S_CAPTURE;
            S_CAPTURE:   state_n = (rom_entry.wait_cs == '0) ? S_FIND_SLOT : S_DELAY;
            S_DELAY:     if (delay_cnt == 8'd1) state_n = S_FIND_SLOT;
            S_FIND_SLOT: if (slot_found) state_n = S_LOAD;
            S_LOAD:      state_n = S_RELEASE;
            S_RELEASE:   state_n = entry_q.last ? S_IDLE : S_FETCH;
            default:     state_n = S_IDLE;
        endcase
    end

    // A controller dropping object_free acknowledges the load; a same-cycle claim still wins.
    always_comb begin
        claimed_n = claimed & object_free;
        if (state == S_LOAD) claimed_n[slot_q] = 1'b1;
    end

    always_ff @(posedge clk_centi_second) begin
        if (reset) begin
            rom_addr               <= '0;
            entry_q                <= '0;
            delay_cnt              <= '0;
            slot_q                 <= '0;
            claimed                <= '0;
            sync_object_position   <= '1;
            movement_direction     <= '0;
            object_pos_x           <= '0;
            object_pos_y           <= '0;
            object_speed           <= '0;
            object_destroy_time    <= '0;
            object_destroy_trigger <= '0;
            object_w               <= '0;
            object_h               <= '0;
            busy                   <= 1'b0;
            pattern_done           <= 1'b0;
            stall_count            <= '0;
        end else begin
            claimed              <= claimed_n;
            sync_object_position <= '1;
            pattern_done         <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    rom_addr    <= pattern_base;
                    busy        <= 1'b1;
                    stall_count <= '0;
                end
                S_CAPTURE: begin
                    entry_q   <= rom_entry.attr;
                    delay_cnt <= rom_entry.wait_cs;
                end
                S_DELAY: delay_cnt <= delay_cnt - 8'd1;
                // Strobe is registered here so it is low for exactly the LOAD cycle.
                S_FIND_SLOT: if (slot_found) begin
                    slot_q                         <= slot_idx;
                    sync_object_position[slot_idx] <= 1'b0;
                    movement_direction             <= entry_q.dir;
                    object_pos_x                   <= entry_q.x;
                    object_pos_y                   <= entry_q.y;
                    object_speed                   <= entry_q.speed;
                    object_destroy_time            <= entry_q.destroy_time;
                    object_destroy_trigger         <= entry_q.trigger;
                    object_w                       <= entry_q.w;
                    object_h                       <= entry_q.h;
                end else if (stall_count != 8'hFF) begin
                    stall_count <= stall_count + 8'd1;
                end
                S_LOAD: pattern_done <= entry_q.last;
                S_RELEASE: begin
                    if (entry_q.last) busy     <= 1'b0;
                    else              rom_addr <= rom_addr + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_object_spawn_sequencer.sv
// Self-checking bench: event-scheduled reference model compared every cycle, plus directed literal checks.
module tb_object_spawn_sequencer;

    logic        clk_centi_second = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  pattern_base = 8'h00;
    logic [7:0]  rom_addr;
    logic [66:0] rom_data;
    logic [7:0]  object_free = 8'hFF;
    logic [7:0]  sync_object_position;
    logic [2:0]  movement_direction;
    logic [9:0]  object_pos_x, object_pos_y, object_w, object_h;
    logic [4:0]  object_speed;
    logic [7:0]  object_destroy_time;
    logic [1:0]  object_destroy_trigger;
    logic        busy, pattern_done;
    logic [7:0]  stall_count;

    always #5 clk_centi_second = ~clk_centi_second;

    object_spawn_sequencer dut (
        .clk_centi_second       (clk_centi_second),
        .reset                  (reset),
        .start                  (start),
        .pattern_base           (pattern_base),
        .rom_addr               (rom_addr),
        .rom_data               (rom_data),
        .object_free            (object_free),
        .sync_object_position   (sync_object_position),
        .movement_direction     (movement_direction),
        .object_pos_x           (object_pos_x),
        .object_pos_y           (object_pos_y),
        .object_speed           (object_speed),
        .object_destroy_time    (object_destroy_time),
        .object_destroy_trigger (object_destroy_trigger),
        .object_w               (object_w),
        .object_h               (object_h),
        .busy                   (busy),
        .pattern_done           (pattern_done),
        .stall_count            (stall_count)
    );

    // Pattern ROM: entry fields kept separately, packed into the ROM word image.
    logic [66:0] rom [256];
    logic [7:0]  e_wait [256];
    logic [2:0]  e_dir  [256];
    logic [9:0]  e_x [256], e_y [256], e_w [256], e_h [256];
    logic [4:0]  e_sp [256];
    logic [7:0]  e_dt [256];
    logic [1:0]  e_tr [256];
    logic        e_last [256];

    always @(posedge clk_centi_second) rom_data <= rom[rom_addr];

    task automatic set_entry(input int a, input int wt, input int dir, input int x, input int y,
                             input int sp, input int last);
        e_wait[a] = 8'(wt);      e_dir[a] = 3'(dir);
        e_x[a] = 10'(x);         e_y[a] = 10'(y);
        e_sp[a] = 5'(sp);        e_dt[a] = 8'(a + 7);
        e_tr[a] = 2'(a);         e_w[a] = 10'(x + 3);
        e_h[a] = 10'(y + 5);     e_last[a] = 1'(last);
        rom[a] = {e_wait[a], e_dir[a], e_x[a], e_y[a], e_sp[a], e_dt[a], e_tr[a], e_w[a], e_h[a], e_last[a]};
    endtask

    // Reference model: schedules the edge at which each entry searches, loads and releases.
    int          edge_n = 0;
    int          m_search, m_load, m_rel, m_slot;
    bit          m_active;
    logic [7:0]  m_addr, m_stall, m_claimed, m_sync;
    logic        m_busy, m_done;
    logic [57:0] m_bus;

    task automatic model_edge();
        logic [7:0] cand;
        logic [7:0] prev_claimed;
        edge_n++;
        m_sync = 8'hFF;
        m_done = 1'b0;
        if (reset) begin
            m_active = 0; m_busy = 0; m_addr = 0; m_stall = 0; m_claimed = 0; m_bus = 0;
            m_search = -1; m_load = -1; m_rel = -1; m_slot = 0;
            return;
        end
        prev_claimed = m_claimed;
        m_claimed = m_claimed & object_free;
        if (!m_active) begin
            if (start) begin
                m_active = 1; m_busy = 1; m_addr = pattern_base; m_stall = 0;
                m_search = edge_n + 3 + int'(e_wait[m_addr]);
            end
        end else if (edge_n == m_load) begin
            m_claimed[m_slot] = 1'b1;
            m_done = e_last[m_addr];
        end else if (edge_n == m_rel) begin
            if (e_last[m_addr]) begin
                m_active = 0; m_busy = 0;
            end else begin
                m_addr = m_addr + 8'd1;
                m_search = edge_n + 3 + int'(e_wait[m_addr]);
            end
        end else if (edge_n >= m_search) begin
            cand = object_free & ~prev_claimed;
            if (cand == 8'h00) begin
                if (m_stall != 8'hFF) m_stall = m_stall + 8'd1;
            end else begin
                m_slot = 0;
                while (!cand[m_slot]) m_slot++;
                m_sync[m_slot] = 1'b0;
                m_bus = {e_dir[m_addr], e_x[m_addr], e_y[m_addr], e_sp[m_addr],
                         e_dt[m_addr], e_tr[m_addr], e_w[m_addr], e_h[m_addr]};
                m_load = edge_n + 1;
                m_rel = edge_n + 2;
                m_search = 1 << 30;
            end
        end
    endtask

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;
    int         falls [$];
    logic [7:0] fall_vals [$];
    logic [7:0] fall_addr [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_centi_second);
        model_edge();
        #1;
        if (chk_en) begin
            check("sync", 64'(sync_object_position), 64'(m_sync));
            check("bus", 64'({movement_direction, object_pos_x, object_pos_y, object_speed,
                              object_destroy_time, object_destroy_trigger, object_w, object_h}), 64'(m_bus));
            check("rom_addr", 64'(rom_addr), 64'(m_addr));
            check("busy", 64'(busy), 64'(m_busy));
            check("pattern_done", 64'(pattern_done), 64'(m_done));
            check("stall_count", 64'(stall_count), 64'(m_stall));
            if (sync_object_position !== 8'hFF) begin
                falls.push_back(edge_n);
                fall_vals.push_back(sync_object_position);
                fall_addr.push_back(rom_addr);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        chk_en = 1;
        step();
        reset = 1'b0;
        falls.delete(); fall_vals.delete(); fall_addr.delete();
    endtask

    task automatic pulse_start(input logic [7:0] base);
        pattern_base = base;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_until_done(input string name, input int max_steps);
        bit seen = 0;
        for (int i = 0; i < max_steps && !seen; i++) begin
            step();
            if (pattern_done === 1'b1) seen = 1;
        end
        check(name, 64'(seen), 64'd1);
        step();
    endtask

    initial begin
        for (int a = 0; a < 256; a++) set_entry(a, 0, 0, 0, 0, 0, 1);

        // Reset state
        do_reset();
        check("rst_sync", 64'(sync_object_position), 64'hFF);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_addr", 64'(rom_addr), 64'd0);

        // A: single entry, immediate issue to slot 0
        set_entry(8'h10, 0, 2, 100, 200, 8, 1);
        object_free = 8'hFF;
        pulse_start(8'h10);
        check("A_addr", 64'(rom_addr), 64'h10);
        step(); step();
        check("A_sync_pre", 64'(sync_object_position), 64'hFF);
        step();
        check("A_sync_low", 64'(sync_object_position), 64'hFE);
        check("A_bus", 64'({movement_direction, object_pos_x, object_pos_y, object_speed}),
              64'({3'd2, 10'd100, 10'd200, 5'd8}));
        step();
        check("A_sync_high", 64'(sync_object_position), 64'hFF);
        check("A_done", 64'(pattern_done), 64'd1);
        step();
        check("A_idle", 64'(busy), 64'd0);

        // B: second entry waits 5; slot 0 remains claimed while its free flag stays high
        do_reset();
        set_entry(8'h20, 0, 1, 10, 20, 3, 0);
        set_entry(8'h21, 5, 4, 30, 40, 9, 1);
        pulse_start(8'h20);
        run_until_done("B_done", 40);
        check("B_nstrobes", 64'(falls.size()), 64'd2);
        if (falls.size() >= 2) begin
            check("B_high_gap", 64'(falls[1] - falls[0] - 1), 64'd9);
            check("B_slot1", 64'(fall_vals[1]), 64'hFD);
        end

        // C: no free slot for 20 search cycles, then slot 3 frees up
        do_reset();
        set_entry(8'h30, 2, 6, 50, 60, 1, 1);
        object_free = 8'h00;
        pulse_start(8'h30);
        for (int i = 0; i < 24; i++) step();
        check("C_stall", 64'(stall_count), 64'd20);
        check("C_no_strobe", 64'(falls.size()), 64'd0);
        object_free = 8'h08;
        step();
        check("C_slot3", 64'(sync_object_position), 64'hF7);
        run_until_done("C_done", 10);

        // D: reset during the LOAD cycle
        do_reset();
        object_free = 8'hFF;
        set_entry(8'h40, 0, 3, 1, 2, 4, 0);
        set_entry(8'h41, 0, 5, 7, 8, 2, 1);
        pulse_start(8'h40);
        step(); step(); step();
        check("D_in_load", 64'(sync_object_position), 64'hFE);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("D_sync", 64'(sync_object_position), 64'hFF);
        check("D_busy", 64'(busy), 64'd0);
        check("D_stall", 64'(stall_count), 64'd0);
        pulse_start(8'h41);
        run_until_done("D_restart", 20);

        // E: address wraps from 0xFF to 0x00; start while busy is ignored
        do_reset();
        set_entry(8'hFF, 3, 7, 11, 22, 6, 0);
        set_entry(8'h00, 0, 0, 33, 44, 7, 1);
        pulse_start(8'hFF);
        check("E_addr", 64'(rom_addr), 64'hFF);
        step(); step();
        pulse_start(8'h80);
        run_until_done("E_done", 30);
        check("E_nstrobes", 64'(falls.size()), 64'd2);
        if (falls.size() >= 2) check("E_wrap_addr", 64'(fall_addr[1]), 64'h00);

        // F: priority with object_free = 0x05
        do_reset();
        object_free = 8'h05;
        set_entry(8'h50, 0, 1, 5, 6, 1, 0);
        set_entry(8'h51, 0, 2, 7, 8, 2, 1);
        pulse_start(8'h50);
        run_until_done("F_done", 30);
        check("F_nstrobes", 64'(falls.size()), 64'd2);
        if (falls.size() >= 2) begin
            check("F_first", 64'(fall_vals[0]), 64'hFE);
            check("F_second", 64'(fall_vals[1]), 64'hFB);
        end

        // Randomized traffic against the model
        do_reset();
        for (int a = 0; a < 256; a++)
            set_entry(a, $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 1023),
                      $urandom_range(0, 1023), $urandom_range(0, 31), ($urandom_range(0, 2) == 0) ? 1 : 0);
        for (int i = 0; i < 3000; i++) begin
            object_free  = 8'($urandom) | 8'($urandom);
            start        = ($urandom_range(0, 5) == 0);
            pattern_base = 8'($urandom);
            reset        = ($urandom_range(0, 399) == 0);
            step();
        end
        reset = 1'b0;
        start = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
